// File: rtl/irq_encoder_pkg.sv
// -----------------------------------------------------------------------------
// irq_encoder_pkg
// Shared definitions for the ezRISC interrupt request encoder:
//   - default source count and code width (N_SRC must equal 2**CODE_W)
//   - presentation FSM state encoding (also exported on the debug port)
// -----------------------------------------------------------------------------
package irq_encoder_pkg;

    localparam int N_SRC_DEF  = 16;
    localparam int CODE_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // nothing presented, waiting for an enabled pending source
        PRESENT = 2'd1,  // irq_code offered to the CPU, waiting for irq_ack
        SERVICE = 2'd2   // CPU servicing, waiting for eoi
    } state_t;

endpackage

// File: rtl/irq_encoder_pri_enc.sv
// -----------------------------------------------------------------------------
// pri_enc_16to4
// Combinational lowest-set-bit priority encoder.
// Ports:
//   i_vec  [15:0]  request vector (already masked by the caller)
//   o_idx  [3:0]   index of the lowest set bit (0 when i_vec is zero)
//   o_any          1 when any bit of i_vec is set
// -----------------------------------------------------------------------------
module pri_enc_16to4 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx,
    output logic        o_any
);

    always_comb begin
        o_idx = 4'd0;
        o_any = |i_vec;
        // Scan from the top down so the last hit is the lowest index.
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_encoder.sv
// -----------------------------------------------------------------------------
// irq_encoder
// Collapses N_SRC request lines into a CODE_W-bit source code for the ezRISC
// control unit. Requests are latched into a pending register (edge or level
// triggered), filtered by a mask, and the lowest enabled index is presented.
//
// Handshake: irq_valid/irq_code are held stable while presented; the CPU takes
// the code by pulsing irq_ack (clears that pending bit, in_service rises).
// in_service stays high until a one-cycle eoi. A presentation is withdrawn
// (pending kept) if its mask bit drops before the ack; ack wins a tie.
//
// Ports:
//   clock, resetn        clock (rising edge), async active-low reset
//   req        [N_SRC]   raw request lines
//   mask_we, mask_wdata  mask register write (1 = source enabled)
//   irq_ack, eoi         CPU accept / end-of-interrupt pulses
//   irq_valid, irq_code  registered presentation to the CPU
//   in_service           acknowledged interrupt being serviced
//   pending, mask        register read-back
//   dbg_state  [2]       current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module irq_encoder
    import irq_encoder_pkg::*;
#(
    parameter int N_SRC  = N_SRC_DEF,
    parameter int CODE_W = CODE_W_DEF,
    parameter bit EDGE   = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [N_SRC-1:0]  req,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_wdata,
    input  logic              irq_ack,
    input  logic              eoi,
    output logic              irq_valid,
    output logic [CODE_W-1:0] irq_code,
    output logic              in_service,
    output logic [N_SRC-1:0]  pending,
    output logic [N_SRC-1:0]  mask,
    output logic [1:0]        dbg_state
);

    state_t              r_state;
    logic [N_SRC-1:0]    r_req_q;
    logic [N_SRC-1:0]    r_pending;
    logic [N_SRC-1:0]    r_mask;
    logic                r_valid;
    logic [CODE_W-1:0]   r_code;
    logic                r_in_service;

    logic [N_SRC-1:0]    w_set;
    logic [N_SRC-1:0]    w_clr;
    logic [N_SRC-1:0]    w_mask_next;
    logic [N_SRC-1:0]    w_enabled;
    logic [CODE_W-1:0]   w_sel_idx;
    logic                w_sel_any;
    logic                w_ack_take;

    // A request already high when reset releases counts as an edge because
    // r_req_q comes out of reset at zero.
    assign w_set       = EDGE ? (req & ~r_req_q) : req;
    assign w_ack_take  = (r_state == PRESENT) && irq_ack;
    assign w_mask_next = mask_we ? mask_wdata : r_mask;
    assign w_enabled   = r_pending & r_mask;

    always_comb begin
        w_clr = '0;
        if (w_ack_take) begin
            w_clr[r_code] = 1'b1;
        end
    end

    pri_enc_16to4 u_pri_enc (
        .i_vec (w_enabled),
        .o_idx (w_sel_idx),
        .o_any (w_sel_any)
    );

    // Pending, mask and request history. Set is OR-ed after the clear so a
    // same-cycle set wins.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_req_q   <= req;
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_mask    <= w_mask_next;
        end
    end

    // Presentation FSM with registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_valid      <= 1'b0;
            r_code       <= '0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_any) begin
                        r_code  <= w_sel_idx;
                        r_valid <= 1'b1;
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) begin
                        r_valid      <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= SERVICE;
                    end else if (!w_mask_next[r_code]) begin
                        // Source withdrawn by the mask (including a write
                        // landing this cycle); its pending bit is kept.
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        r_in_service <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_valid      <= 1'b0;
                    r_in_service <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign irq_valid  = r_valid;
    assign irq_code   = r_code;
    assign in_service = r_in_service;
    assign pending    = r_pending;
    assign mask       = r_mask;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_irq_encoder.sv
// -----------------------------------------------------------------------------
// tb_irq_encoder
// Drives a level-triggered (u_lvl, index 0) and an edge-triggered (u_edge,
// index 1) encoder from the same inputs. A behavioural model of each runs
// beside them and is compared on every falling edge; directed sequences add
// literal expectations, followed by a randomized soak.
// -----------------------------------------------------------------------------
module tb_irq_encoder;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] req = '0;
    logic        mask_we = 1'b0;
    logic [15:0] mask_wdata = '0;
    logic        irq_ack = 1'b0;
    logic        eoi = 1'b0;

    logic        v_valid[2];
    logic [3:0]  v_code[2];
    logic        v_insvc[2];
    logic [15:0] v_pend[2];
    logic [15:0] v_mask[2];
    logic [1:0]  v_state[2];

    logic        l_valid, e_valid, l_insvc, e_insvc;
    logic [3:0]  l_code, e_code;
    logic [15:0] l_pend, e_pend, l_mask, e_mask;
    logic [1:0]  l_state, e_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    irq_encoder #(.N_SRC(16), .CODE_W(4), .EDGE(1'b0)) u_lvl (
        .clock(clock), .resetn(resetn), .req(req), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .irq_ack(irq_ack), .eoi(eoi),
        .irq_valid(l_valid), .irq_code(l_code), .in_service(l_insvc),
        .pending(l_pend), .mask(l_mask), .dbg_state(l_state)
    );

    irq_encoder #(.N_SRC(16), .CODE_W(4), .EDGE(1'b1)) u_edge (
        .clock(clock), .resetn(resetn), .req(req), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .irq_ack(irq_ack), .eoi(eoi),
        .irq_valid(e_valid), .irq_code(e_code), .in_service(e_insvc),
        .pending(e_pend), .mask(e_mask), .dbg_state(e_state)
    );

    always_comb begin
        v_valid[0] = l_valid; v_code[0] = l_code; v_insvc[0] = l_insvc;
        v_pend[0]  = l_pend;  v_mask[0] = l_mask; v_state[0] = l_state;
        v_valid[1] = e_valid; v_code[1] = e_code; v_insvc[1] = e_insvc;
        v_pend[1]  = e_pend;  v_mask[1] = e_mask; v_state[1] = e_state;
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting, 1 offering a code, 2 CPU servicing
    logic [15:0] m_pend[2]  = '{default: '0};
    logic [15:0] m_mask[2]  = '{default: '0};
    logic [15:0] m_prev[2]  = '{default: '0};
    int          m_phase[2] = '{default: 0};
    logic        m_valid[2] = '{default: 1'b0};
    logic        m_insvc[2] = '{default: 1'b0};
    logic [3:0]  m_code[2]  = '{default: '0};

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int m = 0; m < 2; m++) begin
                m_pend[m] = '0; m_mask[m] = '0; m_prev[m] = '0;
                m_phase[m] = 0; m_valid[m] = 1'b0; m_insvc[m] = 1'b0;
                m_code[m] = '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                logic [15:0] newly;
                logic [15:0] taken;
                logic [15:0] mask_after;
                int          pick;
                newly      = (m == 1) ? (req & ~m_prev[m]) : req;
                taken      = '0;
                mask_after = mask_we ? mask_wdata : m_mask[m];
                pick       = lowest(m_pend[m] & m_mask[m]);
                if (m_phase[m] == 0 && pick >= 0) begin
                    m_code[m] = 4'(pick); m_valid[m] = 1'b1; m_phase[m] = 1;
                end else if (m_phase[m] == 1 && irq_ack) begin
                    taken[m_code[m]] = 1'b1;
                    m_valid[m] = 1'b0; m_insvc[m] = 1'b1; m_phase[m] = 2;
                end else if (m_phase[m] == 1 && !mask_after[m_code[m]]) begin
                    m_valid[m] = 1'b0; m_phase[m] = 0;
                end else if (m_phase[m] == 2 && eoi) begin
                    m_insvc[m] = 1'b0; m_phase[m] = 0;
                end
                m_pend[m] = (m_pend[m] & ~taken) | newly;
                m_mask[m] = mask_after;
                m_prev[m] = req;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("u%0d_valid", m),   32'(v_valid[m]), 32'(m_valid[m]));
            chk($sformatf("u%0d_code", m),    32'(v_code[m]),  32'(m_code[m]));
            chk($sformatf("u%0d_insvc", m),   32'(v_insvc[m]), 32'(m_insvc[m]));
            chk($sformatf("u%0d_pending", m), 32'(v_pend[m]),  32'(m_pend[m]));
            chk($sformatf("u%0d_mask", m),    32'(v_mask[m]),  32'(m_mask[m]));
            chk($sformatf("u%0d_state", m),   32'(v_state[m]), 32'(m_phase[m]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic write_mask(input logic [15:0] v);
        mask_we = 1'b1; mask_wdata = v;
        cyc();
        mask_we = 1'b0;
    endtask

    task automatic pulse_req(input logic [15:0] v);
        req = v;
        cyc();
        req = '0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1; cyc(); eoi = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc(2);
        chk("rst_valid", 32'(e_valid), 0);
        chk("rst_code",  32'(e_code), 0);
        chk("rst_pend",  32'(e_pend), 0);
        chk("rst_mask",  32'(e_mask), 0);
        resetn = 1'b1;
        write_mask(16'hFFFF);

        // Single pulse on source 5: latency and full handshake.
        pulse_req(16'h0020);
        chk("t1_pend", 32'(e_pend), 32'h0020);
        chk("t1_valid_early", 32'(e_valid), 0);
        cyc();
        chk("t1_valid", 32'(e_valid), 1);
        chk("t1_code",  32'(e_code), 5);
        cyc(3);
        chk("t1_hold", 32'(e_valid), 1);
        do_ack();
        chk("t1_ack_pend",  32'(e_pend), 0);
        chk("t1_ack_insvc", 32'(e_insvc), 1);
        chk("t1_ack_valid", 32'(e_valid), 0);
        do_eoi();
        chk("t1_eoi_insvc", 32'(e_insvc), 0);
        chk("t1_eoi_state", 32'(e_state), 0);

        // Sources 9 and 3 together: 3 first, then 9.
        pulse_req(16'h0208);
        cyc();
        chk("t2_code3", 32'(e_code), 3);
        do_ack();
        do_eoi();
        cyc();
        chk("t2_valid9", 32'(e_valid), 1);
        chk("t2_code9",  32'(e_code), 9);
        chk("t2_pend",   32'(e_pend), 32'h0200);
        do_ack();
        do_eoi();

        // Higher priority arrival does not replace a presented code.
        pulse_req(16'h0080);
        cyc();
        chk("t3_code7", 32'(e_code), 7);
        pulse_req(16'h0002);
        chk("t3_hold7", 32'(e_code), 7);
        chk("t3_pend",  32'(e_pend), 32'h0082);
        do_ack();
        chk("t3_ack_code", 32'(e_code), 7);
        do_eoi();
        cyc();
        chk("t3_code1", 32'(e_code), 1);
        do_ack();
        do_eoi();

        // Mask withdrawal before ack, then re-presentation.
        pulse_req(16'h0010);
        cyc();
        chk("t4_code4", 32'(e_code), 4);
        write_mask(16'hFFEF);
        chk("t4_withdrawn", 32'(e_valid), 0);
        chk("t4_pend4", 32'(e_pend[4]), 1);
        write_mask(16'hFFFF);
        cyc();
        chk("t4_repres", 32'(e_valid), 1);
        chk("t4_code",   32'(e_code), 4);
        do_ack();
        do_eoi();

        // Level mode: held request re-pends after ack.
        req = 16'h0004;
        cyc(2);
        chk("t5_lvl_code", 32'(l_code), 2);
        do_ack();
        chk("t5_lvl_repend",  32'(l_pend), 32'h0004);
        chk("t5_edge_clear",  32'(e_pend), 32'h0000);
        req = '0;
        do_eoi();
        cyc();
        chk("t5_lvl_again",  32'(l_valid), 1);
        chk("t5_edge_quiet", 32'(e_valid), 0);
        do_ack();
        do_eoi();

        // Edge mode: new edge in the ack cycle keeps the bit pending.
        pulse_req(16'h0004);
        cyc();
        chk("t5b_code", 32'(e_code), 2);
        req = 16'h0004; irq_ack = 1'b1;
        cyc();
        req = '0; irq_ack = 1'b0;
        chk("t5b_set_wins", 32'(e_pend), 32'h0004);
        do_eoi();
        cyc();
        chk("t5b_repres", 32'(e_valid), 1);
        do_ack();
        do_eoi();

        // Reset while servicing with pending 8001.
        pulse_req(16'h8001);
        cyc();
        do_ack();
        pulse_req(16'h0001);
        chk("t6_pend",  32'(e_pend), 32'h8001);
        chk("t6_insvc", 32'(e_insvc), 1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_pend",  32'(e_pend), 0);
        chk("t6_rst_insvc", 32'(e_insvc), 0);
        chk("t6_rst_valid", 32'(e_valid), 0);
        chk("t6_rst_state", 32'(e_state), 0);
        cyc(2);
        resetn = 1'b1;
        cyc(3);
        chk("t6_after_valid", 32'(e_valid), 0);

        // Randomized soak.
        write_mask(16'hFFFF);
        for (int i = 0; i < 1500; i++) begin
            req        = 16'($urandom) & 16'($urandom) & 16'($urandom);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 16'($urandom) | 16'($urandom);
            irq_ack    = ($urandom_range(0, 2) == 0);
            eoi        = ($urandom_range(0, 3) == 0);
            cyc();
        end
        req = '0; mask_we = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
